ddram_responder: RTL and testbench



---
 rtl/ddram_pkg.sv | 33 +++
 rtl/ddram_bram.sv | 37 +++
 rtl/ddram_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_ddram_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddram_pkg.sv
// Shared types, bus widths and small helpers for the DDRAM responder.
package ddram_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } ddram_resp_state_t;

  localparam logic [3:0] DDRAM_BASE   = 4'b0011;
  localparam int         DDRAM_AW_BUS = 29;
  localparam int         DDRAM_DW     = 64;
  localparam int         DDRAM_BEW    = 8;

  // A burst count of zero still moves one beat.
  function automatic logic [7:0] burst_len(input logic [7:0] bc);
    if (bc == 8'd0) begin
      return 8'd1;
    end else begin
      return bc;
    end
  endfunction

  // 16-bit Galois LFSR step, taps 16,14,13,11 (right-shifting form).
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    if (cur[0]) begin
      return {1'b0, cur[15:1]} ^ 16'hB400;
    end else begin
      return {1'b0, cur[15:1]};
    end
  endfunction

endpackage

// File: rtl/ddram_bram.sv
// Single-port 64-bit RAM with per-byte write enables and a registered read
// port. The read register only loads on a read, so it holds between reads.
module ddram_bram
  import ddram_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic [DDRAM_BEW-1:0] wr_be,
  input  logic [AW-1:0]        addr,
  input  logic [DDRAM_DW-1:0]  wdata,
  output logic [DDRAM_DW-1:0]  rdata
);

  logic [DDRAM_DW-1:0] mem_r [0:(1<<AW)-1];
  logic [DDRAM_DW-1:0] rdata_r;

  // Byte-enabled write into the array (contents are never reset).
  always_ff @(posedge clk) begin
    for (int b = 0; b < DDRAM_BEW; b++) begin
      if (wr_be[b]) begin
        mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // One-cycle registered read.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/ddram_responder.sv
// DDRAM port responder: serves reads and writes from an internal block RAM,
// with a fixed read latency and optional LFSR-driven BUSY stalls.
module ddram_responder
  import ddram_pkg::*;
#(
  parameter int          AW        = 12,
  parameter logic [3:0]  BASE      = DDRAM_BASE,
  parameter int          RD_LAT    = 2,
  parameter bit          STALL_EN  = 1'b0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    DDRAM_CLK,
  input  logic                    reset,
  output logic                    DDRAM_BUSY,
  input  logic [7:0]              DDRAM_BURSTCNT,
  input  logic [DDRAM_AW_BUS-1:0] DDRAM_ADDR,
  input  logic                    DDRAM_RD,
  input  logic [DDRAM_DW-1:0]     DDRAM_DIN,
  input  logic [DDRAM_BEW-1:0]    DDRAM_BE,
  input  logic                    DDRAM_WE,
  output logic [DDRAM_DW-1:0]     DDRAM_DOUT,
  output logic                    DDRAM_DOUT_READY,
  output logic                    err
);

  ddram_resp_state_t state_r, state_s;
  logic [AW-1:0]     base_r, base_s;
  logic [7:0]        n_r, n_s;        // beats in current burst
  logic [7:0]        cnt_r, cnt_s;    // next beat index to write / read-issue
  logic [7:0]        out_r, out_s;    // read beats already delivered
  logic              miss_r, miss_s;
  logic              err_r, err_s;
  logic              busy_r, busy_s;
  logic [15:0]       lfsr_r, lfsr_s;

  logic                 hit_s, rd_acc_s, we_acc_s;
  logic [AW-1:0]        burst_idx_s;
  logic                 ram_rd_s, ram_zero_s;
  logic [DDRAM_BEW-1:0] ram_be_s;
  logic [AW-1:0]        ram_addr_s;
  logic [DDRAM_DW-1:0]  ram_q_s, s1_data_s;

  // vld_r[1] lines up with the RAM read register; vld_r[RD_LAT] is DOUT_READY.
  logic [RD_LAT:1] vld_r;
  logic            zero1_r;           // miss flag travelling with the RAM read

  logic unused_addr_s;
  assign unused_addr_s = ^DDRAM_ADDR[24:AW];

  assign hit_s       = (DDRAM_ADDR[28:25] == BASE);
  assign rd_acc_s    = DDRAM_RD & ~busy_r;
  assign we_acc_s    = DDRAM_WE & ~busy_r;
  assign burst_idx_s = base_r + AW'(cnt_r);

  // Next-state, RAM access and error decisions for the control FSM.
  always_comb begin
    state_s    = state_r;
    base_s     = base_r;
    n_s        = n_r;
    cnt_s      = cnt_r;
    out_s      = out_r;
    miss_s     = miss_r;
    err_s      = err_r;
    ram_rd_s   = 1'b0;
    ram_be_s   = 8'h00;
    ram_addr_s = DDRAM_ADDR[AW-1:0];
    ram_zero_s = miss_r;
    case (state_r)
      IDLE: begin
        if (we_acc_s) begin
          // Write wins over a simultaneous read; the read is flagged.
          ram_be_s = hit_s ? DDRAM_BE : 8'h00;
          base_s   = DDRAM_ADDR[AW-1:0];
          n_s      = burst_len(DDRAM_BURSTCNT);
          cnt_s    = 8'd1;
          miss_s   = ~hit_s;
          err_s    = err_r | ~hit_s | rd_acc_s;
          if (burst_len(DDRAM_BURSTCNT) != 8'd1) begin
            state_s = WR_BURST;
          end else begin
            state_s = IDLE;
          end
        end else if (rd_acc_s) begin
          // First read is issued in the accept cycle so RD_LAT=1 works.
          ram_rd_s   = 1'b1;
          ram_zero_s = ~hit_s;
          base_s     = DDRAM_ADDR[AW-1:0];
          n_s        = burst_len(DDRAM_BURSTCNT);
          cnt_s      = 8'd1;
          out_s      = 8'd0;
          miss_s     = ~hit_s;
          err_s      = err_r | ~hit_s;
          state_s    = RD_BURST;
        end else begin
          state_s = IDLE;
        end
      end
      WR_BURST: begin
        ram_addr_s = burst_idx_s;
        err_s      = err_r | rd_acc_s;
        if (we_acc_s) begin
          ram_be_s = miss_r ? 8'h00 : DDRAM_BE;
          cnt_s    = cnt_r + 8'd1;
          if ((cnt_r + 8'd1) == n_r) begin
            state_s = IDLE;
          end else begin
            state_s = WR_BURST;
          end
        end else begin
          state_s = WR_BURST;
        end
      end
      RD_BURST: begin
        ram_addr_s = burst_idx_s;
        if (cnt_r != n_r) begin
          ram_rd_s = 1'b1;
          cnt_s    = cnt_r + 8'd1;
        end else begin
          ram_rd_s = 1'b0;
        end
        if (vld_r[RD_LAT]) begin
          out_s = out_r + 8'd1;
          if (out_r == (n_r - 8'd1)) begin
            state_s = IDLE;
          end else begin
            state_s = RD_BURST;
          end
        end else begin
          state_s = RD_BURST;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    lfsr_s = lfsr_step(lfsr_r);
    busy_s = (state_s == RD_BURST) | (STALL_EN & lfsr_s[0]);
  end

  // Control state, burst bookkeeping, stall LFSR and the registered BUSY.
  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      base_r  <= '0;
      n_r     <= 8'd0;
      cnt_r   <= 8'd0;
      out_r   <= 8'd0;
      miss_r  <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      lfsr_r  <= LFSR_SEED;
    end else begin
      state_r <= state_s;
      base_r  <= base_s;
      n_r     <= n_s;
      cnt_r   <= cnt_s;
      out_r   <= out_s;
      miss_r  <= miss_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
      lfsr_r  <= lfsr_s;
    end
  end

  // Read-valid pipeline plus the miss flag held alongside the RAM read data.
  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      vld_r   <= '0;
      zero1_r <= 1'b1;
    end else begin
      vld_r[1] <= ram_rd_s;
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_r[k] <= vld_r[k-1];
      end
      if (ram_rd_s) begin
        zero1_r <= ram_zero_s;
      end
    end
  end

  assign s1_data_s = zero1_r ? 64'h0 : ram_q_s;

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign DDRAM_DOUT = s1_data_s;
    end else begin : g_latn
      logic [DDRAM_DW-1:0] dpipe_r [2:RD_LAT];
      // Remaining latency stages; each loads only with valid data so DOUT holds.
      always_ff @(posedge DDRAM_CLK or posedge reset) begin
        if (reset) begin
          for (int k = 2; k <= RD_LAT; k++) begin
            dpipe_r[k] <= 64'h0;
          end
        end else begin
          if (vld_r[1]) begin
            dpipe_r[2] <= s1_data_s;
          end
          for (int k = 3; k <= RD_LAT; k++) begin
            if (vld_r[k-1]) begin
              dpipe_r[k] <= dpipe_r[k-1];
            end
          end
        end
      end
      assign DDRAM_DOUT = dpipe_r[RD_LAT];
    end
  endgenerate

  ddram_bram #(.AW(AW)) u_bram (
    .clk   (DDRAM_CLK),
    .rd_en (ram_rd_s),
    .wr_be (ram_be_s),
    .addr  (ram_addr_s),
    .wdata (DDRAM_DIN),
    .rdata (ram_q_s)
  );

  assign DDRAM_BUSY       = busy_r;
  assign DDRAM_DOUT_READY = vld_r[RD_LAT];
  assign err              = err_r;

endmodule

// File: tb/tb_ddram_responder.sv
// Directed and randomised checks of ddram_responder with stalls enabled.
module tb_ddram_responder;

  localparam int RD_LAT = 2;

  logic        DDRAM_CLK = 1'b0;
  logic        reset = 1'b1;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT = 8'd0;
  logic [28:0] DDRAM_ADDR = 29'd0;
  logic        DDRAM_RD = 1'b0;
  logic [63:0] DDRAM_DIN = 64'd0;
  logic [7:0]  DDRAM_BE = 8'd0;
  logic        DDRAM_WE = 1'b0;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        err;

  ddram_responder #(
    .AW(12), .BASE(4'b0011), .RD_LAT(RD_LAT), .STALL_EN(1'b1), .LFSR_SEED(16'hACE1)
  ) dut (
    .DDRAM_CLK(DDRAM_CLK), .reset(reset), .DDRAM_BUSY(DDRAM_BUSY),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_RD(DDRAM_RD),
    .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE),
    .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .err(err)
  );

  always #5 DDRAM_CLK = ~DDRAM_CLK;

  int vectors = 0;
  int miscompares = 0;

  // Reference stall LFSR, stepped on the same edges as the design's.
  logic [15:0] lfsr_m;
  always @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  logic [63:0] rd_d[$];
  int          rd_k[$];
  logic        busy_h[$];
  logic        lfsr_h[$];
  logic [63:0] wq_d[$];
  logic [7:0]  wq_be[$];
  logic [63:0] mdl [0:4095];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Wait (bounded) for the strobes already on the bus to be accepted.
  task automatic accept_wait(input string what);
    bit b;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge DDRAM_CLK); b = DDRAM_BUSY;
      @(posedge DDRAM_CLK);
      if (!b) ok = 1'b1;
    end
    #1;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL %s_accept: BUSY held for 200 cycles, required acceptance", what);
    end
  endtask

  task automatic wr_burst(input logic [28:0] a, input logic [7:0] bc);
    @(posedge DDRAM_CLK); #1;
    DDRAM_ADDR = a; DDRAM_BURSTCNT = bc;
    for (int i = 0; i < wq_d.size(); i++) begin
      DDRAM_WE = 1'b1; DDRAM_DIN = wq_d[i]; DDRAM_BE = wq_be[i];
      accept_wait("wr");
    end
    DDRAM_WE = 1'b0;
    wq_d.delete(); wq_be.delete();
  endtask

  task automatic rd_burst(input logic [28:0] a, input logic [7:0] bc, input int kmax);
    rd_d.delete(); rd_k.delete(); busy_h.delete(); lfsr_h.delete();
    @(posedge DDRAM_CLK); #1;
    DDRAM_ADDR = a; DDRAM_BURSTCNT = bc; DDRAM_RD = 1'b1;
    accept_wait("rd");
    DDRAM_RD = 1'b0;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge DDRAM_CLK);
      busy_h.push_back(DDRAM_BUSY);
      lfsr_h.push_back(lfsr_m[0]);
      if (DDRAM_DOUT_READY) begin
        rd_d.push_back(DDRAM_DOUT); rd_k.push_back(k);
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge DDRAM_CLK); reset = 1'b1;
    @(negedge DDRAM_CLK); @(negedge DDRAM_CLK); reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge DDRAM_CLK);
    @(negedge DDRAM_CLK);
    vectors++; if (DDRAM_BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", DDRAM_BUSY); end
    vectors++; if (DDRAM_DOUT_READY !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", DDRAM_DOUT_READY); end
    vectors++; if (DDRAM_DOUT !== 64'h0) begin miscompares++; $display("FAIL reset_dout got %h want 0", DDRAM_DOUT); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    wq_d.push_back(64'h1122334455667788); wq_be.push_back(8'hFF);
    wr_burst(29'h06000010, 8'd1);
    rd_burst(29'h06000010, 8'd1, 5);
    vectors++; if (rd_d.size() != 1) begin miscompares++; $display("FAIL single_beats got %0d want 1", rd_d.size()); end
    vectors++; if (rd_k.size() < 1 || rd_k[0] != 2) begin miscompares++; $display("FAIL single_latency got %0d want 2", rd_k.size() ? rd_k[0] : -1); end
    vectors++; if (rd_d.size() < 1 || rd_d[0] !== 64'h1122334455667788) begin miscompares++; $display("FAIL single_data got %h want 1122334455667788", rd_d.size() ? rd_d[0] : 64'hx); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL single_err got %b want 0", err); end
  endtask

  task automatic test_byte_enables();
    wq_d.push_back(64'hAAAA_AAAA_AAAA_AAAA); wq_be.push_back(8'h0C);
    wr_burst(29'h06000010, 8'd1);
    rd_burst(29'h06000010, 8'd1, 4);
    vectors++; if (rd_d.size() != 1 || rd_d[0] !== 64'h11223344AAAA7788) begin miscompares++; $display("FAIL be_data got %h (%0d beats) want 11223344aaaa7788", rd_d.size() ? rd_d[0] : 64'hx, rd_d.size()); end
  endtask

  task automatic test_burst_wrap();
    bit bz;
    for (int i = 1; i <= 4; i++) begin wq_d.push_back(64'(i)); wq_be.push_back(8'hFF); end
    wr_burst(29'h06000FFE, 8'd4);
    rd_burst(29'h06000FFE, 8'd4, 7);
    vectors++; if (rd_d.size() != 4) begin miscompares++; $display("FAIL burst_beats got %0d want 4", rd_d.size()); end
    for (int i = 0; i < rd_d.size() && i < 4; i++) begin
      vectors++;
      if (rd_d[i] !== 64'(i + 1) || rd_k[i] != 2 + i) begin
        miscompares++; $display("FAIL burst_beat%0d got %h at k=%0d want %h at k=%0d", i, rd_d[i], rd_k[i], 64'(i + 1), 2 + i);
      end
    end
    bz = 1'b1;
    for (int k = 0; k < 5; k++) bz = bz & busy_h[k];
    vectors++; if (!bz) begin miscompares++; $display("FAIL burst_busy_high got %b%b%b%b%b want 11111", busy_h[0], busy_h[1], busy_h[2], busy_h[3], busy_h[4]); end
    vectors++; if (busy_h[5] !== lfsr_h[5]) begin miscompares++; $display("FAIL burst_busy_after got %b want %b", busy_h[5], lfsr_h[5]); end
    rd_burst(29'h06000000, 8'd1, 4);
    vectors++; if (rd_d.size() != 1 || rd_d[0] !== 64'd3) begin miscompares++; $display("FAIL wrap_idx0 got %h want 3", rd_d.size() ? rd_d[0] : 64'hx); end
  endtask

  task automatic test_reset_mid_burst();
    int beats;
    beats = 0;
    @(posedge DDRAM_CLK); #1;
    DDRAM_ADDR = 29'h06000FFE; DDRAM_BURSTCNT = 8'd4; DDRAM_RD = 1'b1;
    accept_wait("rst_rd");
    DDRAM_RD = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge DDRAM_CLK);
      if (DDRAM_DOUT_READY) beats++;
    end
    reset = 1'b1; #1;
    vectors++; if (beats != 2) begin miscompares++; $display("FAIL rstmid_beats_before got %0d want 2", beats); end
    vectors++; if (DDRAM_DOUT_READY !== 1'b0 || DDRAM_BUSY !== 1'b0) begin miscompares++; $display("FAIL rstmid_outputs got ready=%b busy=%b want 0 0", DDRAM_DOUT_READY, DDRAM_BUSY); end
    vectors++; if (DDRAM_DOUT !== 64'h0) begin miscompares++; $display("FAIL rstmid_dout got %h want 0", DDRAM_DOUT); end
    @(negedge DDRAM_CLK); @(negedge DDRAM_CLK); reset = 1'b0;
    rd_burst(29'h06000FFF, 8'd1, 4);
    vectors++; if (rd_d.size() != 1 || rd_d[0] !== 64'd2 || rd_k[0] != 2) begin miscompares++; $display("FAIL rstmid_reread got %h (%0d beats) want 2", rd_d.size() ? rd_d[0] : 64'hx, rd_d.size()); end
  endtask

  task automatic test_collision();
    int beats;
    beats = 0;
    @(posedge DDRAM_CLK); #1;
    DDRAM_ADDR = 29'h06000020; DDRAM_BURSTCNT = 8'd1; DDRAM_DIN = 64'h0BAD_F00D_0000_0001;
    DDRAM_BE = 8'hFF; DDRAM_RD = 1'b1; DDRAM_WE = 1'b1;
    accept_wait("coll");
    DDRAM_RD = 1'b0; DDRAM_WE = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge DDRAM_CLK);
      if (DDRAM_DOUT_READY) beats++;
    end
    vectors++; if (beats != 0) begin miscompares++; $display("FAIL coll_read_dropped got %0d beats want 0", beats); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL coll_err got %b want 1", err); end
    rd_burst(29'h06000020, 8'd1, 4);
    vectors++; if (rd_d.size() != 1 || rd_d[0] !== 64'h0BAD_F00D_0000_0001) begin miscompares++; $display("FAIL coll_write got %h want 0badf00d00000001", rd_d.size() ? rd_d[0] : 64'hx); end
  endtask

  task automatic test_miss();
    pulse_reset();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL miss_err_before got %b want 0", err); end
    rd_burst(29'h00000000, 8'd2, 6);
    vectors++; if (rd_d.size() != 2) begin miscompares++; $display("FAIL miss_beats got %0d want 2", rd_d.size()); end
    for (int i = 0; i < rd_d.size() && i < 2; i++) begin
      vectors++;
      if (rd_d[i] !== 64'h0 || rd_k[i] != 2 + i) begin
        miscompares++; $display("FAIL miss_beat%0d got %h at k=%0d want 0 at k=%0d", i, rd_d[i], rd_k[i], 2 + i);
      end
    end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL miss_err got %b want 1", err); end
    wq_d.push_back(64'hDEAD_BEEF_DEAD_BEEF); wq_be.push_back(8'hFF);
    wr_burst(29'h00000000, 8'd1);
    rd_burst(29'h06000000, 8'd1, 4);
    vectors++; if (rd_d.size() != 1 || rd_d[0] !== 64'd3) begin miscompares++; $display("FAIL miss_write_blocked got %h want 3", rd_d.size() ? rd_d[0] : 64'hx); end
  endtask

  task automatic test_random_stalls();
    logic [11:0] idx, j;
    logic [63:0] d;
    logic [7:0]  be;
    int          n;
    logic [7:0]  bc;
    for (int i = 0; i < 20; i++) begin
      d = {32'hC0DE0000, 32'(i)};
      wq_d.push_back(d); wq_be.push_back(8'hFF);
      j = 12'hFF8 + 12'(i);
      mdl[j] = d;
    end
    wr_burst(29'h06000FF8, 8'd20);
    for (int t = 0; t < 200; t++) begin
      idx = 12'hFF8 + 12'($urandom_range(0, 15));
      n   = $urandom_range(1, 4);
      bc  = (n == 1 && $urandom_range(0, 1) == 1) ? 8'd0 : 8'(n);
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < n; b++) begin
          d  = {$urandom, $urandom};
          be = 8'($urandom_range(0, 255));
          wq_d.push_back(d); wq_be.push_back(be);
          j = idx + 12'(b);
          for (int y = 0; y < 8; y++) if (be[y]) mdl[j][8*y +: 8] = d[8*y +: 8];
        end
        wr_burst({4'b0011, 13'd0, idx}, bc);
      end else begin
        rd_burst({4'b0011, 13'd0, idx}, bc, n + 3);
        vectors++;
        if (rd_d.size() != n) begin miscompares++; $display("FAIL rand_beats t=%0d got %0d want %0d", t, rd_d.size(), n); end
        for (int b = 0; b < rd_d.size() && b < n; b++) begin
          j = idx + 12'(b);
          vectors++;
          if (rd_d[b] !== mdl[j] || rd_k[b] != 2 + b) begin
            miscompares++; $display("FAIL rand_data t=%0d beat %0d got %h at k=%0d want %h at k=%0d", t, b, rd_d[b], rd_k[b], mdl[j], 2 + b);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_byte_enables();
    test_burst_wrap();
    test_reset_mid_burst();
    test_collision();
    test_miss();
    test_random_stalls();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
